// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
// Holds the request size encodings, the FSM state encoding, and the
// lane helpers used to pull a sub-word out of a memory word (with
// extension) and to merge a sub-word into a memory word.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } state_e;

    // Extract the addressed byte/half from a little-endian word and
    // zero- or sign-extend it to 32 bits. Lane k is bits [8k+7:8k].
    function automatic logic [31:0] lane_extract(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [1:0]  size,
        input logic        is_unsigned
    );
        logic [4:0]  sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = {lane, 3'b000};
        b  = 8'(word >> sh);
        h  = 16'(word >> sh);
        case (size)
            SZ_BYTE: lane_extract = is_unsigned ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_HALF: lane_extract = is_unsigned ? {16'd0, h} : {{16{h[15]}}, h};
            SZ_WORD: lane_extract = word;
            default: lane_extract = 32'd0;
        endcase
    endfunction

    // Replace the addressed lane(s) of word with the right-justified wdata.
    // A word-sized merge simply yields wdata.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [1:0]  size,
        input logic [31:0] wdata
    );
        logic [4:0]  sh;
        logic [31:0] mask;
        sh = {lane, 3'b000};
        case (size)
            SZ_BYTE: mask = 32'h0000_00FF << sh;
            SZ_HALF: mask = 32'h0000_FFFF << sh;
            default: mask = 32'hFFFF_FFFF;
        endcase
        lane_merge = (word & ~mask) | ((wdata << sh) & mask);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane alignment for the load/store unit.
// Ports:
//   word        in  32  word read from memory
//   lane        in  2   byte lane (addr[1:0])
//   size        in  2   access size encoding
//   is_unsigned in  1   1 = zero-extend loads, 0 = sign-extend
//   wdata       in  32  right-justified store data
//   load_data   out 32  extracted and extended load value
//   merged_word out 32  word with the target lane(s) replaced by wdata
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    assign load_data   = lane_extract(word, lane, size, is_unsigned);
    assign merged_word = lane_merge(word, lane, size, wdata);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator for a byte-addressable little-endian
// data memory. All memory accesses are word aligned; sub-word stores are
// done as read-modify-write over two cycles.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   req_valid/req_ready          request handshake
//   req_we, req_size, req_unsigned, req_addr, req_wdata   request fields
//   resp_valid, resp_rdata, resp_err                      one-cycle response
//   mem_addr, mem_wdata, mem_read, mem_write, mem_rdata   memory interface
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_SIZE = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_SIZE);

    state_e      state_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;
    logic [31:0] rmw_addr_q;
    logic [31:0] rmw_word_q;

    logic        idle_take;   // request taken, ignoring reset (reset branch dominates in the flop)
    logic        req_err;
    logic        do_access;
    logic        word_store;
    logic [31:0] word_base;
    logic [31:0] load_val;
    logic [31:0] merged_word;

    assign req_ready  = (state_q == ST_IDLE) && !rst;
    assign idle_take  = req_valid && (state_q == ST_IDLE);
    assign word_base  = {req_addr[31:2], 2'b00};

    assign req_err = (req_size == SZ_ILL)
                  || ((req_size == SZ_HALF) && req_addr[0])
                  || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                  || (req_addr >= ADDR_LIMIT);

    assign do_access  = req_valid && req_ready && !req_err;
    assign word_store = req_we && (req_size == SZ_WORD);

    // Loads and the read half of a sub-word store both read the word.
    assign mem_read  = do_access && !word_store;
    assign mem_write = (do_access && word_store) || ((state_q == ST_RMW_WR) && !rst);

    always_comb begin
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (!rst) begin
            if (state_q == ST_RMW_WR) begin
                mem_addr  = rmw_addr_q;
                mem_wdata = rmw_word_q;
            end else begin
                mem_addr = word_base;
                if (do_access && word_store) begin
                    mem_wdata = req_wdata;
                end
            end
        end
    end

    mem_lane_align u_align (
        .word        (mem_rdata),
        .lane        (req_addr[1:0]),
        .size        (req_size),
        .is_unsigned (req_unsigned),
        .wdata       (req_wdata),
        .load_data   (load_val),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            rmw_addr_q   <= 32'd0;
            rmw_word_q   <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    resp_valid_q <= idle_take;
                    resp_err_q   <= idle_take && req_err;
                    resp_rdata_q <= (idle_take && !req_err && !req_we) ? load_val : 32'd0;
                    if (idle_take && !req_err && req_we && !word_store) begin
                        // Sub-word store: hold the merged word for the write cycle;
                        // the response comes after the write.
                        resp_valid_q <= 1'b0;
                        rmw_addr_q   <= word_base;
                        rmw_word_q   <= merged_word;
                        state_q      <= ST_RMW_WR;
                    end
                end
                ST_RMW_WR: begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'd0;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule
